// File: rtl/pet_bus_pkg.sv
// Shared definitions for the bus request path: default widths, default timeout and FSM states.
package pet_bus_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 17;
    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        RESP    = 2'd3
    } req_state_e;

endpackage : pet_bus_pkg

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous level/strobe inputs.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule : sync2

// File: rtl/bus_request_ctl.sv
// Single-transaction request controller: latches a command, handshakes pending/done with
// the downstream sync block, and returns the result (or a timeout error) over valid/ready.
module bus_request_ctl
    import pet_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_we,
    output logic                  pending,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wr_data,
    output logic                  bus_we,
    input  logic                  done,
    input  logic [DATA_WIDTH-1:0] bus_rd_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    req_state_e            state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic                  pending_q,    pending_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q,    wr_data_d;
    logic                  we_q,         we_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q,  resp_data_d;
    logic                  resp_err_q,   resp_err_d;
    logic                  cmd_ready_q,  cmd_ready_d;
    logic                  busy_q,       busy_d;
    logic                  done_s;

    sync2 #(.WIDTH(1)) u_done_sync (
        .clk   (clk),
        .reset (reset),
        .d     (done),
        .q     (done_s)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        addr_d       = addr_q;
        wr_data_d    = wr_data_q;
        we_d         = we_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        cmd_ready_d  = cmd_ready_q;
        busy_d       = busy_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    wr_data_d   = cmd_data;
                    we_d        = cmd_we;
                    cnt_d       = '0;
                    pending_d   = 1'b1;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                // A completion seen in the same cycle as the timeout takes priority.
                if (done_s) begin
                    resp_data_d = we_q ? '0 : bus_rd_data;
                    resp_err_d  = 1'b0;
                    pending_d   = 1'b0;
                    state_d     = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    pending_d   = 1'b0;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                // Hold off until done has cleared so the next request cannot see it.
                if (!done_s) begin
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            we_q         <= we_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign pending     = pending_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = wr_data_q;
    assign bus_we      = we_q;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_err    = resp_err_q;
    assign busy        = busy_q;

endmodule : bus_request_ctl

// File: tb/tb_bus_request_ctl.sv
// Scoreboard bench for bus_request_ctl: randomized commands against a behavioural model of
// the controller and of the downstream sync block (done after N cycles, held H cycles late).
module tb_bus_request_ctl;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 8;
    localparam int          NEVER = -1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
        int            delay;
        logic [DW-1:0] rd;
        int            hold;
    } txn_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } resp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          cmd_we = 1'b0;
    logic          pending;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data;
    logic          bus_we;
    logic          done;
    logic          done_m = 1'b0;
    logic          done_stray = 1'b0;
    logic [DW-1:0] rd_m = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic          busy;

    int    checks = 0;
    int    errors = 0;
    int    bp_mode = 2;
    logic  aborting = 1'b0;
    txn_t  cur;
    txn_t  txn_q[$];
    resp_t exp_q[$];
    int    done_low_cnt = 0;
    logic  rv_prev = 1'b0;
    txn_t  sm_t;
    int    sm_cyc;
    resp_t mon_e;

    assign done = done_m | done_stray;

    bus_request_ctl #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_we      (cmd_we),
        .pending     (pending),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_we      (bus_we),
        .done        (done),
        .bus_rd_data (rd_m),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                                input int dly, input logic [DW-1:0] rd, input int hold);
        txn_t t;
        t.addr = a; t.data = d; t.we = we; t.delay = dly; t.rd = rd; t.hold = hold;
        return t;
    endfunction

    // Reference: a command that never sees done times out with data 0; writes return 0.
    function automatic resp_t model(input txn_t t);
        resp_t r;
        if (t.delay == NEVER) begin
            r.data = '0; r.err = 1'b1;
        end else begin
            r.data = t.we ? '0 : t.rd; r.err = 1'b0;
        end
        return r;
    endfunction

    // Accept monitor: valid && ready at the negedge means the command is taken on the next edge.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            txn_q.push_back(cur);
            exp_q.push_back(model(cur));
        end
    end

    always @(posedge clk) done_low_cnt <= done ? 0 : done_low_cnt + 1;

    // Response monitor / scoreboard check.
    always @(negedge clk) begin
        check("busy_vs_cmd_ready", busy, !cmd_ready);
        if (resp_valid && !rv_prev) begin
            check("pending_low_at_resp", pending, 0);
            check("done_cleared_before_resp", done_low_cnt >= 3, 1);
        end
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_data", resp_data, mon_e.data);
                check("resp_err", resp_err, mon_e.err);
            end
        end
        rv_prev = resp_valid;
    end

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       resp_ready = 1'($urandom_range(0, 1));
            1:       resp_ready = 1'b0;
            default: resp_ready = 1'b1;
        endcase
    end

    // Downstream sync model: raise done N negedges after pending is seen, drop it H negedges
    // after pending falls; bus outputs must stay at the accepted command throughout.
    initial begin
        forever begin
            @(negedge clk);
            if (pending) begin
                if (txn_q.size() == 0) begin
                    check("pending_without_accept", 1, 0);
                    sm_t = mk('0, '0, 1'b0, NEVER, '0, 0);
                end else begin
                    sm_t = txn_q.pop_front();
                end
                sm_cyc = 0;
                while (pending && sm_cyc < 100) begin
                    check("bus_addr", bus_addr, sm_t.addr);
                    check("bus_wr_data", bus_wr_data, sm_t.data);
                    check("bus_we", bus_we, sm_t.we);
                    if (sm_t.delay != NEVER && sm_cyc == sm_t.delay) begin
                        done_m = 1'b1;
                        rd_m   = sm_t.rd;
                    end
                    sm_cyc++;
                    @(negedge clk);
                end
                if (pending) check("pending_stuck", 1, 0);
                if (!aborting)
                    check("issue_length", sm_cyc, (sm_t.delay == NEVER) ? TO : sm_t.delay + 3);
                if (done_m) begin
                    repeat (sm_t.hold) @(negedge clk);
                    done_m = 1'b0;
                end
            end
        end
    end

    task automatic send(input txn_t t);
        int n;
        cur = t;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = t.addr;
        cmd_data  = t.data;
        cmd_we    = t.we;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 300);
        if (n >= 300) check("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_data  = DW'($urandom);
        cmd_we    = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("pending_after_accept", pending, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("idle_timeout", 1, 0);
    endtask

    initial begin
        int   n;
        logic [DW-1:0] snap_d;
        logic          snap_e;
        txn_t t;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_pending", pending, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Stray done while idle is ignored.
        done_stray = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stray_busy", busy, 0);
            check("stray_pending", pending, 0);
        end
        done_stray = 1'b0;
        repeat (4) @(posedge clk);

        send(mk(17'h08000, 8'h00, 1'b0, 5, 8'hA5, 0));
        wait_idle();
        send(mk(17'h0E810, 8'h3C, 1'b1, 3, 8'h77, 0));
        wait_idle();
        send(mk(17'h1FFFF, 8'h11, 1'b0, NEVER, 8'h00, 0));
        wait_idle();
        send(mk(17'h00123, 8'h00, 1'b0, 2, 8'h5A, 3));
        send(mk(17'h00456, 8'h00, 1'b0, 1, 8'hC3, 0));
        wait_idle();

        // Backpressure: response must hold steady while unacknowledged.
        bp_mode = 1;
        send(mk(17'h0AAAA, 8'h00, 1'b0, 2, 8'h81, 1));
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("bp_resp_timeout", 1, 0);
        snap_d = resp_data;
        snap_e = resp_err;
        check("bp_snap_data", snap_d, 8'h81);
        repeat (10) begin
            @(negedge clk);
            check("bp_resp_valid", resp_valid, 1);
            check("bp_resp_data", resp_data, snap_d);
            check("bp_resp_err", resp_err, snap_e);
            check("bp_cmd_ready", cmd_ready, 0);
        end
        bp_mode = 2;
        wait_idle();

        // Reset while a request is in ISSUE.
        send(mk(17'h05555, 8'h00, 1'b0, NEVER, 8'h00, 0));
        @(negedge clk);
        aborting = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        repeat (4) @(posedge clk);
        aborting = 1'b0;

        // Randomized back-to-back traffic with random response backpressure.
        bp_mode = 0;
        for (int i = 0; i < 40; i++) begin
            t = mk(AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 5)),
                   DW'($urandom), int'($urandom_range(0, 3)));
            send(t);
        end
        wait_idle();
        bp_mode = 2;
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_bus_request_ctl
